// File: rtl/dbi_tx_arb_pkg.sv
// Shared definitions for the DBI TX arbiter: FSM encodings, default bus width
// and the grant decode helper.
package dbi_tx_arb_pkg;

  localparam int DBI_IF_D_W_DFLT = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_S0 = 2'd1;
  localparam logic [1:0] GNT_S1 = 2'd2;

  function automatic logic [1:0] gntOneHot(input logic [1:0] st);
    return {st == GNT_S1, st == GNT_S0};
  endfunction

endpackage

// File: rtl/dbi_tx_arb_if.sv
// Bundle of the two requester ports, the PHY port and the grant status.
// The slave modport is the arbiter's view; master is the environment's view.
interface dbi_tx_arb_if
  import dbi_tx_arb_pkg::*;
#(
  parameter int DBI_IF_D_W = DBI_IF_D_W_DFLT
);

  logic [DBI_IF_D_W-1:0] s0_cmd_typ_i;
  logic [DBI_IF_D_W-1:0] s0_cmd_dat_i;
  logic                  s0_last_i;
  logic                  s0_vld_i;
  logic                  s0_rdy_o;

  logic [DBI_IF_D_W-1:0] s1_cmd_typ_i;
  logic [DBI_IF_D_W-1:0] s1_cmd_dat_i;
  logic                  s1_last_i;
  logic                  s1_vld_i;
  logic                  s1_rdy_o;

  logic                  dtp_tx_rdy_i;
  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o;
  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o;
  logic                  dtp_tx_last_o;
  logic                  dtp_tx_vld_o;

  logic [1:0]            arb_gnt_o;

  modport slave (
    input  s0_cmd_typ_i, s0_cmd_dat_i, s0_last_i, s0_vld_i,
    output s0_rdy_o,
    input  s1_cmd_typ_i, s1_cmd_dat_i, s1_last_i, s1_vld_i,
    output s1_rdy_o,
    input  dtp_tx_rdy_i,
    output dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o, dtp_tx_vld_o,
    output arb_gnt_o
  );

  modport master (
    output s0_cmd_typ_i, s0_cmd_dat_i, s0_last_i, s0_vld_i,
    input  s0_rdy_o,
    output s1_cmd_typ_i, s1_cmd_dat_i, s1_last_i, s1_vld_i,
    input  s1_rdy_o,
    output dtp_tx_rdy_i,
    input  dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o, dtp_tx_vld_o,
    input  arb_gnt_o
  );

endinterface

// File: rtl/dbi_tx_arb_slice.sv
// One-entry registered pipeline slice: loads on an input handshake, empties on
// an output handshake, and accepts a new beat in the same cycle it drains.
module dbi_tx_arb_slice #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  logic         load;

  assign in_rdy_o = !vld_q || out_rdy_i;
  assign load     = in_vld_i && in_rdy_o;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

endmodule

// File: rtl/dbi_tx_arb.sv
// Two-requester DBI TX arbiter holding the grant for whole transactions.
// Define DBI_TX_ARB_RR_EN for round-robin; otherwise s0 has fixed priority.
module dbi_tx_arb
  import dbi_tx_arb_pkg::*;
#(
  parameter int DBI_IF_D_W = DBI_IF_D_W_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  dbi_tx_arb_if.slave  bus
);

  localparam int W = 2 * DBI_IF_D_W + 1;

  logic [1:0]   state_q, state_d;
  logic         armed_q;
  logic         selVld;
  logic [W-1:0] selBeat;
  logic [W-1:0] outBeat;
  logic         sliceInRdy;
  logic         load;
  logic         pickS1;

  always_comb begin
    selVld  = 1'b0;
    selBeat = '0;
    case (state_q)
      GNT_S0: begin
        selVld  = bus.s0_vld_i;
        selBeat = {bus.s0_cmd_typ_i, bus.s0_cmd_dat_i, bus.s0_last_i};
      end
      GNT_S1: begin
        selVld  = bus.s1_vld_i;
        selBeat = {bus.s1_cmd_typ_i, bus.s1_cmd_dat_i, bus.s1_last_i};
      end
      default: ;
    endcase
  end

  assign load         = selVld && sliceInRdy;
  assign bus.s0_rdy_o = (state_q == GNT_S0) && sliceInRdy;
  assign bus.s1_rdy_o = (state_q == GNT_S1) && sliceInRdy;
  assign bus.arb_gnt_o = gntOneHot(state_q);

`ifdef DBI_TX_ARB_RR_EN
  // The pointer names the preferred requester and moves away from whoever just finished.
  logic rrPtr_q, rrPtr_d;

  assign pickS1 = bus.s1_vld_i && (!bus.s0_vld_i || rrPtr_q);

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (load && selBeat[0]) rrPtr_d = (state_q == GNT_S0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rrPtr_q <= 1'b0;
    else        rrPtr_q <= rrPtr_d;
  end
`else
  assign pickS1 = bus.s1_vld_i && !bus.s0_vld_i;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (armed_q && (bus.s0_vld_i || bus.s1_vld_i))
          state_d = pickS1 ? GNT_S1 : GNT_S0;
      end
      GNT_S0, GNT_S1: begin
        if (load && selBeat[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // armed_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  dbi_tx_arb_slice #(.W(W)) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (selVld),
    .in_dat_i  (selBeat),
    .in_rdy_o  (sliceInRdy),
    .out_vld_o (bus.dtp_tx_vld_o),
    .out_dat_o (outBeat),
    .out_rdy_i (bus.dtp_tx_rdy_i)
  );

  assign {bus.dtp_tx_cmd_typ_o, bus.dtp_tx_cmd_dat_o, bus.dtp_tx_last_o} = outBeat;

endmodule

// File: tb/tb_dbi_tx_arb.sv
// Scoreboard bench for dbi_tx_arb: directed scenarios plus a randomized phase
// whose expected beat order comes from a transaction-level arbitration model.
module tb_dbi_tx_arb;
  import dbi_tx_arb_pkg::*;

  localparam int DW = 8;
  localparam int BW = 2 * DW + 1;
  localparam int NT = 5;

  typedef logic [BW-1:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dbi_tx_arb_if #(.DBI_IF_D_W(DW)) bus();

  dbi_tx_arb #(.DBI_IF_D_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    compared = 0;
  int    mismatched = 0;
  int    seenBeats = 0;
  beat_t expQ[$];
  bit    randPhy = 1'b0;

  function automatic beat_t mk(input logic [DW-1:0] t, input logic [DW-1:0] d, input logic l);
    return {t, d, l};
  endfunction

  function automatic beat_t outBeat();
    return {bus.dtp_tx_cmd_typ_o, bus.dtp_tx_cmd_dat_o, bus.dtp_tx_last_o};
  endfunction

  function automatic logic [63:0] allOuts();
    return 64'({bus.dtp_tx_vld_o, bus.dtp_tx_last_o, bus.dtp_tx_cmd_typ_o,
                bus.dtp_tx_cmd_dat_o, bus.s0_rdy_o, bus.s1_rdy_o, bus.arb_gnt_o});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic noteTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout, want handshake", name);
  endtask

  task automatic setReq(input int src, input logic v, input beat_t b);
    if (src == 0) begin
      bus.s0_vld_i = v;
      {bus.s0_cmd_typ_i, bus.s0_cmd_dat_i, bus.s0_last_i} = b;
    end else begin
      bus.s1_vld_i = v;
      {bus.s1_cmd_typ_i, bus.s1_cmd_dat_i, bus.s1_last_i} = b;
    end
  endtask

  function automatic logic reqRdy(input int src);
    return (src == 0) ? bus.s0_rdy_o : bus.s1_rdy_o;
  endfunction

  // Present one beat until accepted; call between posedge+1 and the next negedge.
  task automatic driveBeat(input int src, input beat_t b, input bit push);
    bit acc = 1'b0;
    int n = 0;
    setReq(src, 1'b1, b);
    while (!acc) begin
      @(negedge clk);
      acc = reqRdy(src);
      @(posedge clk);
      #1;
      if (!acc) begin
        n++;
        if (n > 300) begin
          noteTimeout($sformatf("accept_s%0d", src));
          break;
        end
      end
    end
    setReq(src, 1'b0, b);
    if (acc && push) expQ.push_back(b);
  endtask

  task automatic runReq(input int src, input beat_t bq[$]);
    bit first = 1'b1;
    foreach (bq[i]) begin
      if (!first && $urandom_range(0, 3) == 0) begin
        setReq(src, 1'b0, bq[i]);
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      driveBeat(src, bq[i], 1'b0);
      first = bq[i][0];
    end
  endtask

  // Random transactions for both requesters; expected order is predicted up front.
  task automatic applyStimulus();
    beat_t q0[$], q1[$], m0[$], m1[$];
    beat_t b;
    int    cnt = 0;
    int    n;
    int    w;
`ifdef DBI_TX_ARB_RR_EN
    bit    pref = 1'b0;
`endif
    for (int s = 0; s < 2; s++) begin
      for (int t = 0; t < NT; t++) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          b = mk(8'($urandom), {1'(s), 7'(cnt)}, k == n - 1);
          if (s == 0) q0.push_back(b);
          else        q1.push_back(b);
          cnt++;
        end
      end
    end
    m0 = q0;
    m1 = q1;
    while (m0.size() != 0 || m1.size() != 0) begin
      int pick;
`ifdef DBI_TX_ARB_RR_EN
      pick = (m0.size() != 0 && m1.size() != 0) ? int'(pref) : ((m0.size() != 0) ? 0 : 1);
      pref = (pick == 0);
`else
      pick = (m0.size() != 0) ? 0 : 1;
`endif
      do begin
        b = (pick == 0) ? m0.pop_front() : m1.pop_front();
        expQ.push_back(b);
      end while (!b[0]);
    end
    randPhy = 1'b1;
    fork
      runReq(0, q0);
      runReq(1, q1);
    join
    w = 0;
    while (expQ.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (expQ.size() != 0) noteTimeout("random_drain");
    randPhy = 1'b0;
    bus.dtp_tx_rdy_i = 1'b1;
  endtask

  initial begin : phyDrv
    forever begin
      @(posedge clk);
      #1;
      if (randPhy) bus.dtp_tx_rdy_i = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: pops the scoreboard on every PHY handshake and checks stall stability.
  initial begin : monitor
    beat_t cur;
    beat_t prev;
    bit    hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        cur = outBeat();
        if (hold) checkOutput("hold_stable", 64'({bus.dtp_tx_vld_o, cur}), 64'({1'b1, prev}));
        if (bus.dtp_tx_vld_o && bus.dtp_tx_rdy_i) begin
          seenBeats++;
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_beat: got 0x%0h, want no beat", cur);
          end else begin
            checkOutput("beat", 64'(cur), 64'(expQ.pop_front()));
          end
        end
        hold = bus.dtp_tx_vld_o && !bus.dtp_tx_rdy_i;
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    beat_t dir[3];
    bit    s0Done;
    int    n;
    int    seenBefore;

    setReq(0, 1'b0, '0);
    setReq(1, 1'b0, '0);
    bus.dtp_tx_rdy_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", allOuts(), 64'd0);

    // Reset release bubble, then a 3-beat s0 transaction with a ready PHY.
    setReq(0, 1'b1, mk(8'h2C, 8'h11, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("gnt_first_edge", 64'(bus.arb_gnt_o), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("gnt_second_edge", 64'(bus.arb_gnt_o), 64'd1);
    dir[0] = mk(8'h2C, 8'h11, 1'b0);
    dir[1] = mk(8'h2C, 8'h22, 1'b0);
    dir[2] = mk(8'h2C, 8'h33, 1'b1);
    fork
      begin
        for (int k = 0; k < 3; k++) driveBeat(0, dir[k], 1'b1);
      end
      begin
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput($sformatf("latency_beat%0d", k), 64'({bus.dtp_tx_vld_o, outBeat()}), 64'({1'b1, dir[k]}));
          checkOutput($sformatf("gnt_beat%0d", k), 64'(bus.arb_gnt_o), (k < 2) ? 64'd1 : 64'd0);
        end
      end
    join
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // PHY stalls for 4 cycles while 0x22 sits in the output slice.
    fork
      for (int k = 0; k < 3; k++) driveBeat(0, dir[k], 1'b1);
      begin
        n = 0;
        while (n < 50) begin
          @(negedge clk);
          if (bus.dtp_tx_vld_o && bus.dtp_tx_cmd_dat_o == 8'h11) break;
          n++;
        end
        if (n >= 50) noteTimeout("stall_wait_11");
        @(posedge clk);
        #1;
        bus.dtp_tx_rdy_i = 1'b0;
        repeat (4) begin
          @(negedge clk);
          checkOutput("stall_out", 64'({bus.dtp_tx_vld_o, bus.dtp_tx_cmd_dat_o}), 64'({1'b1, 8'h22}));
          checkOutput("stall_s0_rdy", 64'(bus.s0_rdy_o), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.dtp_tx_rdy_i = 1'b1;
      end
    join
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // s0 pauses mid-transaction while s1 waits; the grant must not move.
    s0Done = 1'b0;
    fork
      begin
        driveBeat(0, dir[0], 1'b1);
        repeat (3) begin
          @(negedge clk);
          checkOutput("gap_gnt", 64'(bus.arb_gnt_o), 64'd1);
          checkOutput("gap_s1_rdy", 64'(bus.s1_rdy_o), 64'd0);
          @(posedge clk);
          #1;
        end
        driveBeat(0, dir[1], 1'b1);
        driveBeat(0, dir[2], 1'b1);
        s0Done = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        driveBeat(1, mk(8'h2A, 8'h44, 1'b1), 1'b1);
        checkOutput("s1_after_s0_last", 64'(s0Done), 64'd1);
      end
    join
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // Fresh reset so the round-robin pointer starts at s0 for the model.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus();
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // Reset lands while beat 2 of 3 is being offered.
    driveBeat(0, dir[0], 1'b1);
    setReq(0, 1'b1, dir[1]);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outputs", allOuts(), 64'd0);
    setReq(0, 1'b0, dir[1]);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seenBefore = seenBeats;
    driveBeat(1, mk(8'h2C, 8'h29, 1'b1), 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("post_rst_single_count", 64'(seenBeats - seenBefore), 64'd1);
    checkOutput("post_rst_queue_empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
